// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter slice.
//   state_e         arbiter FSM states
//   SZ_B/SZ_H/SZ_W  d_size encodings (2'b11 is illegal)
//   misaligned()    flags illegal sizes and unaligned half/word accesses
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR   = 3'd3,
        ST_RMW1 = 3'd4,
        ST_RMW2 = 3'd5
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: combinational byte-lane logic (little-endian lanes).
//   word      in  32  word read from memory
//   addr_lo   in  2   byte offset within the word
//   size      in  2   SZ_B / SZ_H / SZ_W
//   uns       in  1   zero-extend loads when 1, sign-extend when 0
//   wdata     in  32  right-aligned store data
//   load_data out 32  extracted and extended load value
//   merged    out 32  word with wdata inserted at the addressed lane
module mem_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        unused_wdata_hi;

    always_comb unused_wdata_hi = ^wdata[31:16];

    always_comb begin
        byte_v    = word[{addr_lo, 3'b000} +: 8];
        half_v    = word[{addr_lo[1], 4'b0000} +: 16];
        load_data = word;
        merged    = word;
        case (size)
            SZ_B: begin
                load_data = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit memory bus between instruction fetch and
// data load/store, round-robin on contention.
//   clock, reset (sync, active-high), ce (clock enable, gates all state)
//   f_req/f_addr -> f_ack/f_rdata           fetch port
//   d_req/d_we/d_addr/d_size/d_uns/d_wdata
//     -> d_ack/d_err/d_rdata                data port
//   a/o/w (registered outputs), i (read data, valid the cycle after a is sampled)
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_uns,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] a,
    input  logic [31:0] i,
    output logic [31:0] o,
    output logic        w
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, o_q, o_d, f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic        w_q, w_d, f_ack_q, f_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
    // Owner of the current/most recent grant: 1 = data, 0 = fetch.
    logic        last_data_q, last_data_d;
    logic        grant_f, grant_d;
    logic [31:0] lane_load, lane_merged;
    logic        unused_f_addr_lo;

    always_comb unused_f_addr_lo = ^f_addr[1:0];

    mem_lane u_lane (
        .word      (i),
        .addr_lo   (d_addr[1:0]),
        .size      (d_size),
        .uns       (d_uns),
        .wdata     (d_wdata),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        o_d         = o_q;
        w_d         = w_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        last_data_d = last_data_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        // Fetch wins unless data is also pending and fetch had the last grant.
        grant_f     = f_req && (!d_req || last_data_q);
        grant_d     = d_req && !grant_f;
        case (state_q)
            ST_IDLE: begin
                if (grant_f) begin
                    last_data_d = 1'b0;
                    a_d         = {f_addr[31:2], 2'b00};
                    state_d     = ST_RD1;
                end else if (grant_d) begin
                    last_data_d = 1'b1;
                    if (misaligned(d_size, d_addr[1:0])) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end else begin
                        a_d = {d_addr[31:2], 2'b00};
                        if (!d_we) begin
                            state_d = ST_RD1;
                        end else if (d_size == SZ_W) begin
                            o_d     = d_wdata;
                            w_d     = 1'b1;
                            state_d = ST_WR;
                        end else begin
                            state_d = ST_RMW1;
                        end
                    end
                end
            end
            ST_RD1:  state_d = ST_RD2;
            ST_RD2: begin
                if (last_data_q) begin
                    d_rdata_d = lane_load;
                    d_ack_d   = 1'b1;
                end else begin
                    f_rdata_d = i;
                    f_ack_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_WR: begin
                w_d     = 1'b0;
                d_ack_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RMW1: state_d = ST_RMW2;
            ST_RMW2: begin
                o_d     = lane_merged;
                w_d     = 1'b1;
                state_d = ST_WR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= RESET_ADDR;
            o_q         <= '0;
            w_q         <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            last_data_q <= 1'b1;
        end else if (ce) begin
            state_q     <= state_d;
            a_q         <= a_d;
            o_q         <= o_d;
            w_q         <= w_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            last_data_q <= last_data_d;
        end
    end

    assign a       = a_q;
    assign o       = o_q;
    assign w       = w_q;
    assign f_ack   = f_ack_q;
    assign f_rdata = f_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [31:0] RST_A = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset, ce;
    logic        f_req, f_ack;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_uns, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [31:0] a, i, o;
    logic        w;

    int n_err = 0;
    int n_chk = 0;

    // Memory model: registered read, write on enabled edges with w=1.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q = '0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx;
    logic [31:0] ld_val;
    int          wr_count = 0;
    logic [31:0] last_o = '0;

    always #5 clock = ~clock;

    mem_arbiter #(.RESET_ADDR(RST_A)) dut (
        .clock(clock), .reset(reset), .ce(ce),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_uns(d_uns), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err),
        .d_rdata(d_rdata), .a(a), .i(i), .o(o), .w(w)
    );

    assign i = rd_q;

    always @(posedge clock) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_val;
        end else if (ce) begin
            if (w) begin
                mem[a[9:2]] <= o;
                wr_count    <= wr_count + 1;
                last_o      <= o;
            end
            rd_q <= mem[a[9:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        ld_idx = addr[9:2];
        ld_val = val;
        ld_en  = 1'b1;
        tick();
        ld_en  = 1'b0;
    endtask

    // Issue one data request and wait for d_ack; cycles counts edges from grant.
    task automatic do_data(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output int cycles, output logic err, output logic [31:0] rdata);
        d_we = we; d_addr = addr; d_size = size; d_uns = uns; d_wdata = wdata;
        d_req = 1'b1;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!d_ack && cycles < 40);
        if (!d_ack) cycles = 99;
        err   = d_err;
        rdata = d_rdata;
        d_req = 1'b0;
        tick();
        check_eq("d_ack_pulse", {31'b0, d_ack}, 32'h0);
    endtask

    int          n, wr0;
    logic        err;
    logic [31:0] rdata, a_hold;
    int          f1, f2, dc;

    initial begin
        reset = 1'b1; ce = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = 2'b10; d_uns = 1'b0; d_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_a", a, RST_A);
        check_eq("rst_o", o, 32'h0);
        check_eq("rst_w_acks", {28'b0, w, f_ack, d_ack, d_err}, 32'h0);
        check_eq("rst_rdata", f_rdata | d_rdata, 32'h0);

        preload(32'h100, 32'h0000_0013);
        preload(32'h104, 32'h0050_0093);
        preload(32'h200, 32'hCAFE_F00D);

        // Fetch only
        wr0 = wr_count;
        f_addr = 32'h102; f_req = 1'b1;
        tick();
        check_eq("fetch_addr", a, 32'h100);
        n = 1;
        while (!f_ack && n < 40) begin tick(); n++; end
        check_eq("fetch_lat", n, 3);
        check_eq("fetch_data", f_rdata, 32'h0000_0013);
        f_req = 1'b0;
        tick();
        check_eq("fetch_pulse", {31'b0, f_ack}, 32'h0);
        check_eq("fetch_no_wr", wr_count - wr0, 0);

        // Contention: reset so last grant is data, then raise both together
        reset = 1'b1; tick(); reset = 1'b0;
        f_addr = 32'h100; f_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h200; d_size = 2'b10; d_uns = 1'b0; d_req = 1'b1;
        f1 = 0; f2 = 0; dc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (f_ack) begin
                if (f1 == 0) begin
                    f1 = c;
                    check_eq("cont_f1_data", f_rdata, 32'h0000_0013);
                    f_addr = 32'h104;   // fetch re-requests while data still waits
                end else begin
                    f2 = c;
                    check_eq("cont_f2_data", f_rdata, 32'h0050_0093);
                    f_req = 1'b0;
                end
            end
            if (d_ack) begin
                dc = c;
                check_eq("cont_d_data", d_rdata, 32'hCAFE_F00D);
                d_req = 1'b0;
            end
        end
        check_eq("cont_f1_cyc", f1, 3);
        check_eq("cont_d_cyc", dc, 6);
        check_eq("cont_f2_cyc", f2, 9);

        // Byte store
        preload(32'h200, 32'h1122_3344);
        wr0 = wr_count;
        do_data(1'b1, 32'h203, 2'b00, 1'b0, 32'h0000_00AB, n, err, rdata);
        check_eq("bst_lat", n, 4);
        check_eq("bst_err", {31'b0, err}, 32'h0);
        check_eq("bst_o", last_o, 32'hAB22_3344);
        check_eq("bst_wr", wr_count - wr0, 1);
        check_eq("bst_mem", mem[8'h80], 32'hAB22_3344);

        // Loads
        preload(32'h200, 32'h8001_1234);
        do_data(1'b0, 32'h202, 2'b01, 1'b0, 32'h0, n, err, rdata);
        check_eq("lh_lat", n, 3);
        check_eq("lh_s", rdata, 32'hFFFF_8001);
        do_data(1'b0, 32'h202, 2'b01, 1'b1, 32'h0, n, err, rdata);
        check_eq("lh_u", rdata, 32'h0000_8001);
        do_data(1'b0, 32'h200, 2'b00, 1'b0, 32'h0, n, err, rdata);
        check_eq("lb0_s", rdata, 32'h0000_0034);
        do_data(1'b0, 32'h203, 2'b00, 1'b0, 32'h0, n, err, rdata);
        check_eq("lb3_s", rdata, 32'hFFFF_FF80);
        do_data(1'b0, 32'h203, 2'b00, 1'b1, 32'h0, n, err, rdata);
        check_eq("lb3_u", rdata, 32'h0000_0080);

        // Half and word stores
        do_data(1'b1, 32'h202, 2'b01, 1'b0, 32'hFFFF_BEEF, n, err, rdata);
        check_eq("sh_mem", mem[8'h80], 32'hBEEF_1234);
        wr0 = wr_count;
        do_data(1'b1, 32'h204, 2'b10, 1'b0, 32'h1234_5678, n, err, rdata);
        check_eq("sw_lat", n, 2);
        check_eq("sw_mem", mem[8'h81], 32'h1234_5678);
        check_eq("sw_wr", wr_count - wr0, 1);

        // Errors
        wr0 = wr_count;
        a_hold = a;
        do_data(1'b0, 32'h201, 2'b10, 1'b0, 32'h0, n, err, rdata);
        check_eq("err_w_lat", n, 1);
        check_eq("err_w_flag", {31'b0, err}, 32'h1);
        check_eq("err_w_a", a, a_hold);
        do_data(1'b0, 32'h200, 2'b11, 1'b0, 32'h0, n, err, rdata);
        check_eq("err_sz_lat", n, 1);
        check_eq("err_sz_flag", {31'b0, err}, 32'h1);
        do_data(1'b1, 32'h201, 2'b01, 1'b0, 32'h0, n, err, rdata);
        check_eq("err_h_flag", {31'b0, err}, 32'h1);
        check_eq("err_a", a, a_hold);
        check_eq("err_no_wr", wr_count - wr0, 0);

        // ce=0 freeze during RMW2, and again with w=1
        preload(32'h200, 32'h1122_3344);
        wr0 = wr_count;
        d_we = 1'b1; d_addr = 32'h200; d_size = 2'b00; d_uns = 1'b0; d_wdata = 32'h55;
        d_req = 1'b1;
        tick(); tick();
        ce = 1'b0;
        a_hold = a;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("ce_hold", {a[31:2], w, d_ack}, {a_hold[31:2], 2'b00});
        end
        ce = 1'b1;
        tick();
        check_eq("ce_w_set", {31'b0, w}, 32'h1);
        check_eq("ce_o", o, 32'h1122_3355);
        ce = 1'b0;
        tick(); tick();
        check_eq("ce_w_held", {30'b0, w, d_ack}, 32'h2);
        check_eq("ce_no_wr", wr_count - wr0, 0);
        ce = 1'b1;
        tick();
        check_eq("ce_ack", {30'b0, w, d_ack}, 32'h1);
        d_req = 1'b0;
        tick();
        check_eq("ce_mem", mem[8'h80], 32'h1122_3355);
        check_eq("ce_wr", wr_count - wr0, 1);

        // Reset in RMW1 aborts the store
        wr0 = wr_count;
        d_we = 1'b1; d_addr = 32'h201; d_size = 2'b00; d_wdata = 32'h77;
        d_req = 1'b1;
        tick();
        reset = 1'b1; d_req = 1'b0;
        tick();
        check_eq("rst_mid_a", a, RST_A);
        check_eq("rst_mid_w_ack", {30'b0, w, d_ack}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("rst_mid_idle", {30'b0, w, d_ack}, 32'h0);
        end
        check_eq("rst_mid_no_wr", wr_count - wr0, 0);
        do_data(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, n, err, rdata);
        check_eq("post_rst_lat", n, 3);
        check_eq("post_rst_data", rdata, 32'h1122_3355);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single 32-bit memory bus (a, i, o, w) between two requesters: instruction fetch and data load/store.
- Grants one requester at a time, with round-robin on contention.
- Sequences read, write and sub-word read-modify-write bus cycles.
- Performs byte-lane extraction with sign or zero extension for loads.
- Replaces the ad-hoc PC/MR address select inside the core.

Parameters:
- RESET_ADDR, 32'h0000_0000, value driven on a while reset is high.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; all state advances only on edges where ce=1
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  32  fetch byte address; bits [1:0] ignored
- f_ack  out  1  one-cycle pulse; f_rdata is valid in the same cycle
- f_rdata  out  32  fetched word
- d_req  in  1  data request; held with all d_* inputs until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_uns  in  1  load zero-extends when 1, sign-extends when 0
- d_wdata  in  32  store data, right-aligned
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  valid with d_ack: misaligned or illegal size
- d_rdata  out  32  extended load data, valid with d_ack
- a  out  32  memory byte address, registered, word-aligned ([1:0]=0)
- i  in  32  memory read data
- o  out  32  memory write data, registered
- w  out  1  memory write strobe, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Memory contract: memory samples a/o/w on an edge; i is valid during the following cycle. Memory is gated by the same ce.
- Reset values: a=RESET_ADDR, o=0, w=0, f_ack=0, d_ack=0, d_err=0, f_rdata=0, d_rdata=0, state=IDLE, last grant=data (so fetch wins first).
- FSM states: IDLE, RD1, RD2, WR, RMW1, RMW2.
- IDLE:
  - Sample the requests. If both are pending, grant the one not granted last; otherwise grant the single requester.
  - Fetch grant: a<={f_addr[31:2],2'b00}, go to RD1.
  - Data request with d_size=11, half at addr[0]=1, or word at addr[1:0]!=0: d_ack=1, d_err=1 on the next edge. No bus cycle; a unchanged; w stays 0.
  - Data load: a<=aligned addr, go to RD1.
  - Word store: a<=aligned addr, o<=d_wdata, w<=1, go to WR.
  - Byte or half store: a<=aligned addr, go to RMW1.
- RD1 -> RD2 unconditionally.
- RD2:
  - Capture i; pulse the granted ack; return to IDLE.
  - Fetch returns i unchanged.
  - Load selects the lane (little-endian: byte n = bits 8n+7:8n) and extends per d_uns.
- WR: w<=0, d_ack pulse, return to IDLE. Write latency is 2 edges from grant.
- RMW1 -> RMW2.
- RMW2: merge d_wdata low byte/half into i at the addressed lane; o<=merged, w<=1, go to WR.
- Latency: load or fetch ack is asserted after the third enabled edge counting the grant edge. Byte/half store ack after the fourth.
- Acks are one cycle wide and cleared on the next enabled edge. Requesters may drop req in the ack cycle. A req still high in IDLE is treated as a new request.
- Only one grant is outstanding; the losing requester waits, with no starvation thanks to round-robin. The last-grant flag updates on each grant, including error acks.
- ce=0 freezes everything: state, a, o, w (including w=1 held), and the ack outputs.
- Reset mid-operation aborts immediately: w=0, no ack, state=IDLE. A half-done RMW never writes.

Decomposition:
- Shared package mem_pkg: FSM state enum, size codes SZ_B/SZ_H/SZ_W, and a misalignment check function.
- Sub-module mem_lane (combinational): load extraction and extension, plus store merge from (word, addr[1:0], size, uns, wdata).
- The arbiter FSM instantiates one mem_lane.

Test Plan:
- Fetch only: f_addr=0x102, mem[0x100]=0x00000013 -> a=0x100, w never high, f_ack one cycle 3 edges after grant, f_rdata=0x00000013.
- Contention: f_req and d_req (load 0x200) rise together after reset -> fetch served first, then data. On the next simultaneous request data is served first.
- Byte store: d_addr=0x203, d_wdata=0xAB, mem[0x200]=0x11223344 -> read, then w=1 for one cycle with o=0xAB223344, d_ack, d_err=0.
- Half loads: mem[0x200]=0x80011234, d_addr=0x202 -> signed d_rdata=0xFFFF8001; d_uns=1 gives 0x00008001.
- Errors: word load at 0x201 or d_size=11 -> d_ack with d_err=1 on the next edge, a unchanged, w=0.
- ce=0 held 5 cycles during RMW2 -> outputs frozen, then completion. Reset asserted in RMW1 -> w=0, no d_ack, next request starts from IDLE.
